// File: rtl/nz_index_scheduler.sv
// Nonzero index scheduler: walks a mask word and emits one absolute index
// per handshake, lowest set bit first, with a per-word completion pulse.
module nz_index_scheduler #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_mask,
    input  logic [IDX_W-1:0]         in_base,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDX_W-1:0]         out_index,
    output logic                     out_last,
    output logic [$clog2(WIDTH)-1:0] out_rank,
    input  logic                     flush,
    output logic                     word_done,
    output logic [$clog2(WIDTH):0]   word_nnz
);

    localparam int LOG = $clog2(WIDTH);
    localparam int NW  = LOG + 1;
    localparam int NN  = 2 * WIDTH - 1;

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_mask;
    logic [IDX_W-1:0] r_base;
    logic [LOG-1:0]   r_rank;
    logic             r_done;
    logic [NW-1:0]    r_nnz;

    logic             w_nv [NN];
    logic [LOG-1:0]   w_np [NN];
    logic [LOG-1:0]   w_pos;
    logic             w_scan;
    logic             w_last;
    logic             w_hs;

    // Heap-ordered tree of 2-input detectors; the left child covers lower bits
    always_comb begin
        for (int i = 0; i < NN; i++) begin
            w_nv[i] = 1'b0;
            w_np[i] = '0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            w_nv[WIDTH-1+i] = r_mask[i];
            w_np[WIDTH-1+i] = LOG'(i);
        end
        for (int n = WIDTH - 2; n >= 0; n--) begin
            w_nv[n] = w_nv[2*n+1] | w_nv[2*n+2];
            w_np[n] = w_nv[2*n+1] ? w_np[2*n+1] : w_np[2*n+2];
        end
    end

    assign w_pos  = w_np[0];
    assign w_scan = (r_state == SCAN);
    assign w_last = w_scan && ((r_mask & (r_mask - WIDTH'(1))) == '0);
    assign w_hs   = w_scan && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (in_valid && (in_mask != '0)) w_next = SCAN;
            SCAN: if (flush || (out_ready && w_last)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = ~w_scan;
        out_valid = w_scan;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask <= '0;
            r_base <= '0;
            r_rank <= '0;
            r_done <= 1'b0;
            r_nnz  <= '0;
        end else begin
            r_done <= 1'b0;
            if (!w_scan) begin
                if (in_valid && (in_mask != '0)) begin
                    r_mask <= in_mask;
                    r_base <= in_base;
                    r_rank <= '0;
                end else if (in_valid) begin
                    r_done <= 1'b1;
                    r_nnz  <= '0;
                end
            end else if (flush) begin
                // The index offered this cycle is not counted
                r_mask <= '0;
                r_done <= 1'b1;
                r_nnz  <= NW'(r_rank);
            end else if (w_hs) begin
                r_mask <= r_mask & ~(WIDTH'(1) << w_pos);
                r_rank <= r_rank + LOG'(1);
                if (w_last) begin
                    r_done <= 1'b1;
                    r_nnz  <= NW'(r_rank) + NW'(1);
                end
            end
        end
    end

    assign out_index = w_scan ? (r_base + IDX_W'(w_pos)) : '0;
    assign out_last  = w_last;
    assign out_rank  = r_rank;
    assign word_done = r_done;
    assign word_nnz  = r_nnz;

endmodule

// File: tb/tb_nz_index_scheduler.sv
// Directed bench for nz_index_scheduler with a queue-based reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_nz_index_scheduler;

    localparam int W  = 16;
    localparam int IW = 10;
    localparam int RW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_mask = '0;
    logic [IW-1:0] in_base = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] out_index;
    logic          out_last;
    logic [RW-1:0] out_rank;
    logic          flush = 1'b0;
    logic          word_done;
    logic [RW:0]   word_nnz;

    int n_checks = 0;
    int n_err    = 0;

    nz_index_scheduler #(.WIDTH(W), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_mask(in_mask), .in_base(in_base),
        .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_last(out_last), .out_rank(out_rank),
        .flush(flush), .word_done(word_done), .word_nnz(word_nnz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: a word becomes the list of its nonzero indices
    bit m_busy = 0;
    bit m_done = 0;
    int m_nnz  = 0;
    int m_cnt  = 0;
    int m_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0;
            m_done = 0;
            m_nnz  = 0;
            m_cnt  = 0;
            m_q.delete();
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (in_valid) begin
                    m_q.delete();
                    for (int i = 0; i < W; i++)
                        if (in_mask[i])
                            m_q.push_back((int'(in_base) + i) % (1 << IW));
                    if (m_q.size() == 0) begin
                        m_done = 1;
                        m_nnz  = 0;
                    end else begin
                        m_busy = 1;
                        m_cnt  = 0;
                    end
                end
            end else if (flush) begin
                m_busy = 0;
                m_done = 1;
                m_nnz  = m_cnt;
                m_q.delete();
            end else if (out_ready) begin
                void'(m_q.pop_front());
                m_cnt++;
                if (m_q.size() == 0) begin
                    m_busy = 0;
                    m_done = 1;
                    m_nnz  = m_cnt;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("m_in_ready", 32'(in_ready), 32'(!m_busy));
        chk("m_out_valid", 32'(out_valid), 32'(m_busy));
        if (m_busy && m_q.size() > 0) begin
            chk("m_out_index", 32'(out_index), 32'(m_q[0]));
            chk("m_out_last", 32'(out_last), 32'(m_q.size() == 1));
            chk("m_out_rank", 32'(out_rank), 32'(m_cnt));
        end
        chk("m_word_done", 32'(word_done), 32'(m_done));
        if (m_done) chk("m_word_nnz", 32'(word_nnz), 32'(m_nnz));
        if (rst) begin
            chk("rst_index", 32'(out_index), 0);
            chk("rst_rank", 32'(out_rank), 0);
            chk("rst_last", 32'(out_last), 0);
            chk("rst_nnz", 32'(word_nnz), 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] m, input logic [IW-1:0] b);
        in_valid = 1'b1;
        in_mask  = m;
        in_base  = b;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        step();
        step();
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 1);
        chk("reset_out_valid", 32'(out_valid), 0);
        rst = 1'b0;
        step();

        // 8421 at base 100
        out_ready = 1'b1;
        send(16'h8421, 10'd100);
        @(negedge clk);
        chk("s1_idx0", 32'(out_index), 100);
        chk("s1_rank0", 32'(out_rank), 0);
        chk("s1_last0", 32'(out_last), 0);
        step();
        @(negedge clk);
        chk("s1_idx1", 32'(out_index), 105);
        step();
        @(negedge clk);
        chk("s1_idx2", 32'(out_index), 110);
        step();
        @(negedge clk);
        chk("s1_idx3", 32'(out_index), 115);
        chk("s1_rank3", 32'(out_rank), 3);
        chk("s1_last3", 32'(out_last), 1);
        chk("s1_busy_ready", 32'(in_ready), 0);
        step();
        @(negedge clk);
        chk("s1_done", 32'(word_done), 1);
        chk("s1_nnz", 32'(word_nnz), 4);
        chk("s1_ready", 32'(in_ready), 1);
        step();

        // empty word
        send(16'h0000, 10'd7);
        @(negedge clk);
        chk("s2_done", 32'(word_done), 1);
        chk("s2_nnz", 32'(word_nnz), 0);
        chk("s2_valid", 32'(out_valid), 0);
        chk("s2_ready", 32'(in_ready), 1);
        step();

        // stall pattern 0,1,0,1
        out_ready = 1'b0;
        send(16'h0003, 10'd50);
        @(negedge clk);
        chk("s3_hold0a", 32'(out_index), 50);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("s3_hold0b", 32'(out_index), 50);
        chk("s3_rank0b", 32'(out_rank), 0);
        step();
        out_ready = 1'b0;
        @(negedge clk);
        chk("s3_hold1a", 32'(out_index), 51);
        chk("s3_last1a", 32'(out_last), 1);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("s3_hold1b", 32'(out_index), 51);
        chk("s3_rank1b", 32'(out_rank), 1);
        step();
        @(negedge clk);
        chk("s3_nnz", 32'(word_nnz), 2);
        step();

        // wrap-around; flush while idle must not block acceptance
        flush = 1'b1;
        send(16'h0030, 10'd1020);
        flush = 1'b0;
        @(negedge clk);
        chk("s4_idx0", 32'(out_index), 0);
        step();
        @(negedge clk);
        chk("s4_idx1", 32'(out_index), 1);
        step();
        step();

        // flush on third handshake
        send(16'hFFFF, 10'd0);
        step();
        step();
        flush = 1'b1;
        @(negedge clk);
        chk("s5_idx2", 32'(out_index), 2);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("s5_done", 32'(word_done), 1);
        chk("s5_nnz", 32'(word_nnz), 2);
        chk("s5_ready", 32'(in_ready), 1);
        chk("s5_valid", 32'(out_valid), 0);
        step();

        // back-to-back words with in_valid held
        in_valid = 1'b1;
        in_mask  = 16'h0101;
        in_base  = 10'd300;
        for (int i = 0; i < 7; i++) step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // stall mix on a dense word
        send(16'h0F0F, 10'd900);
        for (int i = 0; i < 14; i++) begin
            out_ready = i[0] | i[2];
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // reset mid-scan
        send(16'h00F0, 10'd200);
        step();
        rst = 1'b1;
        #1;
        chk("s6_valid", 32'(out_valid), 0);
        chk("s6_index", 32'(out_index), 0);
        chk("s6_ready", 32'(in_ready), 1);
        chk("s6_done", 32'(word_done), 0);
        step();
        rst = 1'b0;
        send(16'h0005, 10'd10);
        @(negedge clk);
        chk("s6_new0", 32'(out_index), 10);
        step();
        @(negedge clk);
        chk("s6_new1", 32'(out_index), 12);
        step();
        @(negedge clk);
        chk("s6_nnz", 32'(word_nnz), 2);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
